// File: rtl/acc_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : acc_cpu_core
// Description : Parametrised accumulator processor with control FSM, datapath
//               and loadable program/data memory (async read, sync write).
//               Optional macro ACC_CPU_SAT_EN makes ADD/SUB saturate on
//               signed overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_cpu_core #(
    parameter int DATA_W = 8,   // must satisfy DATA_W >= ADDR_W + 3
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Enter,
    input  logic [DATA_W-1:0] Input,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] Output,
    output logic              Halt,
    output logic [2:0]        state,
    output logic [2:0]        IR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_INWAIT = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;
    localparam int         MSB      = DATA_W - 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [2:0]          ir_op_q, ir_op_d;
    logic [ADDR_W-1:0]   ir_addr_q, ir_addr_d;
    logic                enter_q, enter_d;

    logic [DATA_W-1:0]   mem_q [2**ADDR_W];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   fetch_word;
    logic [DATA_W-1:0]   mem_rd;

    logic [DATA_W-1:0]   sum_w, diff_w, add_res, sub_res;
    logic                zero_w, pos_w;

    assign fetch_word = mem_q[pc_q];
    assign mem_rd     = mem_q[ir_addr_q];

    // Flags are purely combinational views of the accumulator
    assign zero_w = (a_q == '0);
    assign pos_w  = !a_q[MSB] && !zero_w;

    // Two's complement add/sub, optionally clamped on signed overflow
    always_comb begin
        sum_w  = a_q + mem_rd;
        diff_w = a_q - mem_rd;
`ifdef ACC_CPU_SAT_EN
        // Overflow only possible when operand signs make the result sign impossible
        if ((a_q[MSB] == mem_rd[MSB]) && (sum_w[MSB] != a_q[MSB]))
            add_res = a_q[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            add_res = sum_w;
        if ((a_q[MSB] != mem_rd[MSB]) && (diff_w[MSB] != a_q[MSB]))
            sub_res = a_q[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sub_res = diff_w;
`else
        add_res = sum_w;
        sub_res = diff_w;
`endif
    end

    // Next-state, datapath updates and memory write-port selection
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        ir_op_d   = ir_op_q;
        ir_addr_d = ir_addr_q;
        enter_d   = Enter;
        mem_we    = 1'b0;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                // External loading only while the core is not running
                mem_we = prog_we;
                if (Start) begin
                    pc_d    = '0;
                    a_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_op_d   = fetch_word[MSB -: 3];
                ir_addr_d = fetch_word[ADDR_W-1:0];
                pc_d      = pc_q + 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                if (ir_op_q == OP_IN)
                    state_d = S_INWAIT;
                else if (ir_op_q == OP_HALT)
                    state_d = S_HALT;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (ir_op_q)
                    OP_LOAD:  a_d = mem_rd;
                    OP_STORE: begin
                        mem_we    = 1'b1;
                        mem_waddr = ir_addr_q;
                        mem_wdata = a_q;
                    end
                    OP_ADD:   a_d = add_res;
                    OP_SUB:   a_d = sub_res;
                    OP_JZ:    if (zero_w) pc_d = ir_addr_q;
                    OP_JPOS:  if (pos_w)  pc_d = ir_addr_q;
                    default:  ;
                endcase
            end
            S_INWAIT: begin
                // Only a fresh press counts; a button already held must be released first
                if (Enter && !enter_q) begin
                    a_d     = Input;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Core registers with asynchronous active-low reset
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            a_q       <= '0;
            ir_op_q   <= '0;
            ir_addr_q <= '0;
            enter_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            ir_op_q   <= ir_op_d;
            ir_addr_q <= ir_addr_d;
            enter_q   <= enter_d;
        end
    end

    // Memory array is deliberately not reset so a loaded program survives Reset
    always_ff @(posedge Clock) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    assign Output = a_q;
    assign Halt   = (state_q == S_HALT);
    assign state  = state_q;
    assign IR     = ir_op_q;

endmodule
`default_nettype wire
